spart_driver: RTL
=================

// Module: spart_driver
// PURPOSE
//  Processor-side initiator for the mini SPART bus_interface. Programs the baud divisor
//  selected by br_cfg, then services the UART over iocs/iorw/ioaddr/databus: reads bytes
//  when rda is set, and writes user or echo bytes when tbr is set. Sits between board
//  I/O (switches, user logic) and spart; replaces the hand-driven bench stimulus.
// PARAMETERS
//  DIV0  16'h0515  divisor for br_cfg=00 (4800 baud, 100 MHz clk, 16x oversample)
//  DIV1  16'h028A  divisor for br_cfg=01 (9600)
//  DIV2  16'h0145  divisor for br_cfg=10 (19200)
//  DIV3  16'h00A2  divisor for br_cfg=11 (38400)
//  ECHO  1         1: every received byte is queued for retransmit; 0: receive only
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous active-high reset
//  br_cfg       in   2  baud select (board switches)
//  iocs         out  1  bus chip select; one cycle per transaction
//  iorw         out  1  1=read, 0=write
//  ioaddr       out  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//  databus_out  out  8  write data to spart
//  databus_in   in   8  read data from spart (valid in cycle iocs&iorw)
//  rda          in   1  receive data available
//  tbr          in   1  transmit buffer ready
//  tx_req       in   1  1-cycle pulse: send tx_data
//  tx_data      in   8  byte for tx_req
//  tx_busy      out  1  a transmit byte is pending or configuration in progress
//  rx_valid     out  1  1-cycle pulse: rx_data holds a new byte
//  rx_data      out  8  last byte read
//  cfg_done     out  1  divisor programmed for current br_cfg
// BEHAVIOUR
//  Reset: iocs=0, iorw=1, ioaddr=00, databus_out=00, rx_valid=0, rx_data=00,
//   cfg_done=0, tx_busy=1, pending-tx flag clear. Reset mid-transaction aborts at once.
//  All outputs registered. Transaction = exactly one cycle with iocs=1; spart captures
//   writes / driver samples databus_in at the closing clk edge. Every transaction is
//   followed by >=1 cycle with iocs=0 (lets rda/tbr settle).
//  FSM: CFG_LO -> CFG_HI -> IDLE; from IDLE: RD or WR_TX; every non-IDLE state -> GAP -> IDLE.
//   CFG_LO: iocs=1,iorw=0,ioaddr=10,databus_out=DIV[7:0]. CFG_HI: ioaddr=11, DIV[15:8].
//   Exit from reset enters CFG_LO on first clk edge after rst falls.
//   cfg_done rises on entry to IDLE after CFG_HI; br_cfg registered at CFG_LO entry.
//   IDLE priority: (1) br_cfg != registered cfg -> cfg_done=0, CFG_LO;
//   (2) rda -> RD; (3) pending & tbr -> WR_TX; else stay.
//   RD: iocs=1,iorw=1,ioaddr=00; rx_data<=databus_in at closing edge; rx_valid=1 the
//    following cycle (GAP). If ECHO and no pending byte: pending<=1, byte<=databus_in.
//    If ECHO and pending already set: received byte not echoed (still reported).
//   WR_TX: iocs=1,iorw=0,ioaddr=00,databus_out=pending byte; pending cleared at edge.
//  tx_req accepted only when tx_busy=0 (captured to pending byte); ignored otherwise.
//  tx_busy = pending | ~cfg_done. Status address 01 is never accessed by this block.
//  Between transactions iorw returns to 1, ioaddr holds last value, databus_out holds.
// TESTING
//  Reset, br_cfg=01: cycle1 iocs=1,iorw=0,ioaddr=10,data=8A; cycle2 ioaddr=11,data=02;
//   cycle3 iocs=0; cycle4 cfg_done=1, tx_busy=0.
//  After cfg, tx_req with tx_data=A5, tbr=1 -> one WR_TX cycle ioaddr=00,data=A5; tx_busy
//   falls after it; spart loopback line carries A5.
//  ECHO=1, rda=1 with databus_in=3C -> RD cycle, rx_valid pulse with rx_data=3C, then
//   WR_TX of 3C once tbr=1.
//  rda=1 and pending byte with tbr=1 in same IDLE cycle -> RD first, GAP, then WR_TX.
//  br_cfg 01->11 while idle -> cfg_done=0, CFG_LO data=A2, CFG_HI data=00, cfg_done=1.
//  rst asserted during CFG_HI -> iocs=0 same cycle; after release full CFG sequence restarts.

Source files
------------

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
// Module  : spart_driver
// Brief   : Processor-side bus initiator for spart. It programs the baud divisor,
//           then services receive and transmit.
// Revision: 1.0
// ============================================================================
module spart_driver #(
    parameter logic [15:0] DIV0 = 16'h0515,
    parameter logic [15:0] DIV1 = 16'h028A,
    parameter logic [15:0] DIV2 = 16'h0145,
    parameter logic [15:0] DIV3 = 16'h00A2,
    parameter bit          ECHO = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] databus_out,
    input  logic [7:0] databus_in,
    input  logic       rda,
    input  logic       tbr,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       cfg_done
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_CFG_LO = 3'd1,
        S_CFG_HI = 3'd2,
        S_IDLE   = 3'd3,
        S_RD     = 3'd4,
        S_WR_TX  = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    localparam logic [1:0] c_ADDR_BUF    = 2'b00;
    localparam logic [1:0] c_ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] c_ADDR_DIV_HI = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] cfg_q, cfg_d;
    logic       iocs_q, iocs_d;
    logic       iorw_q, iorw_d;
    logic [1:0] ioaddr_q, ioaddr_d;
    logic [7:0] dout_q, dout_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       cfg_done_q, cfg_done_d;
    logic       tx_busy_q, tx_busy_d;
    logic       pend_q, pend_d;
    logic [7:0] pend_byte_q, pend_byte_d;

    logic [15:0] w_div_new;
    logic [15:0] w_div_cur;

    function automatic logic [15:0] div_sel(input logic [1:0] sel);
        case (sel)
            2'b00:   div_sel = DIV0;
            2'b01:   div_sel = DIV1;
            2'b10:   div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    endfunction

    assign w_div_new = div_sel(br_cfg);
    assign w_div_cur = div_sel(cfg_q);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        iocs_d      = 1'b0;
        iorw_d      = 1'b1;
        ioaddr_d    = ioaddr_q;
        dout_d      = dout_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        cfg_done_d  = cfg_done_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;

        case (state_q)
            S_RST, S_IDLE: begin
                if (state_q == S_RST || br_cfg != cfg_q) begin
                    state_d    = S_CFG_LO;
                    cfg_d      = br_cfg;
                    cfg_done_d = 1'b0;
                    iocs_d     = 1'b1;
                    iorw_d     = 1'b0;
                    ioaddr_d   = c_ADDR_DIV_LO;
                    dout_d     = w_div_new[7:0];
                end else if (rda) begin
                    state_d  = S_RD;
                    iocs_d   = 1'b1;
                    ioaddr_d = c_ADDR_BUF;
                end else if (pend_q && tbr) begin
                    state_d  = S_WR_TX;
                    iocs_d   = 1'b1;
                    iorw_d   = 1'b0;
                    ioaddr_d = c_ADDR_BUF;
                    dout_d   = pend_byte_q;
                end
            end
            S_CFG_LO: begin
                state_d  = S_CFG_HI;
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = c_ADDR_DIV_HI;
                dout_d   = w_div_cur[15:8];
            end
            S_RD: begin
                state_d    = S_GAP;
                rx_data_d  = databus_in;
                rx_valid_d = 1'b1;
                // A byte already waiting to go out wins; the new one is only reported.
                if (ECHO && !pend_q) begin
                    pend_d      = 1'b1;
                    pend_byte_d = databus_in;
                end
            end
            S_WR_TX: begin
                state_d = S_GAP;
                pend_d  = 1'b0;
            end
            S_GAP: begin
                state_d    = S_IDLE;
                cfg_done_d = 1'b1;
            end
            default: state_d = S_GAP;
        endcase

        if (tx_req && !tx_busy_q) begin
            pend_d      = 1'b1;
            pend_byte_d = tx_data;
        end
    end

    assign tx_busy_d = pend_d | ~cfg_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RST;
            cfg_q       <= 2'b00;
            iocs_q      <= 1'b0;
            iorw_q      <= 1'b1;
            ioaddr_q    <= 2'b00;
            dout_q      <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            cfg_done_q  <= 1'b0;
            tx_busy_q   <= 1'b1;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            iocs_q      <= iocs_d;
            iorw_q      <= iorw_d;
            ioaddr_q    <= ioaddr_d;
            dout_q      <= dout_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            cfg_done_q  <= cfg_done_d;
            tx_busy_q   <= tx_busy_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
        end
    end

    assign iocs        = iocs_q;
    assign iorw        = iorw_q;
    assign ioaddr      = ioaddr_q;
    assign databus_out = dout_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign cfg_done    = cfg_done_q;
    assign tx_busy     = tx_busy_q;

endmodule
`default_nettype wire
